// File: rtl/vpg_pkg.sv
// Shared constants for the video pattern generator path: mode codes,
// default mode count and the mode-selector state encoding.
package vpg_pkg;

   localparam int VPG_MODE_W    = 4;
   localparam int VPG_NUM_MODES = 10;

   localparam logic [3:0] FHD_1920x1080p60 = 4'd0;
   localparam logic [3:0] HD_1280x720p60   = 4'd1;
   localparam logic [3:0] SXGA_1280x1024p60 = 4'd2;
   localparam logic [3:0] XGA_1024x768p60  = 4'd3;
   localparam logic [3:0] SVGA_800x600p60  = 4'd4;
   localparam logic [3:0] VGA_640x480p60   = 4'd5;

   typedef enum logic [1:0] {
      S_PWRUP = 2'd0,
      S_IDLE  = 2'd1,
      S_REQ   = 2'd2
   } vpg_state_e;

endpackage

// File: rtl/vpg_mode_sel_if.sv
// Key, load and request/acknowledge signals between the host side and the
// mode selector.
interface vpg_mode_sel_if #(
   parameter int MODE_W = 4
);
   logic              mode_up;
   logic              mode_down;
   logic              mode_load;
   logic [MODE_W-1:0] mode_load_value;
   logic              mode_ack;
   logic              vpg_mode_change;
   logic [MODE_W-1:0] vpg_mode;
   logic              pending;

   modport master (
      output mode_up, mode_down, mode_load, mode_load_value, mode_ack,
      input  vpg_mode_change, vpg_mode, pending
   );

   modport slave (
      input  mode_up, mode_down, mode_load, mode_load_value, mode_ack,
      output vpg_mode_change, vpg_mode, pending
   );
endinterface

// File: rtl/vpg_key_debounce.sv
// Single-key debouncer: a new level is accepted after DEBOUNCE_TICKS
// consecutive differing samples; a release (0->1) yields a one-tick event.
module vpg_key_debounce #(
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clk_en,
   input  logic key_in,
   output logic key_level,
   output logic release_evt
);
   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

   logic [CNT_W-1:0] cnt_r;
   logic             level_r;
   logic             evt_r;

   // Run-length counter of samples differing from the accepted level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r   <= '0;
         level_r <= 1'b1;
         evt_r   <= 1'b0;
      end else if (clk_en) begin
         if (key_in != level_r) begin
            if (cnt_r == CNT_W'(DEBOUNCE_TICKS - 1)) begin
               level_r <= key_in;
               cnt_r   <= '0;
               evt_r   <= (key_in == 1'b1);
            end else begin
               cnt_r <= cnt_r + CNT_W'(1);
               evt_r <= 1'b0;
            end
         end else begin
            cnt_r <= '0;
            evt_r <= 1'b0;
         end
      end
   end

   assign key_level   = level_r;
   assign release_evt = evt_r;

endmodule

// File: rtl/vpg_mode_sel.sv
// Video-mode selector: debounced up/down keys and direct loads produce a
// mode-change request held until the downstream reconfiguration acknowledges it.
module vpg_mode_sel
   import vpg_pkg::*;
#(
   parameter int MODE_W         = VPG_MODE_W,
   parameter int NUM_MODES      = VPG_NUM_MODES,
   parameter int DEFAULT_MODE   = int'(FHD_1920x1080p60),
   parameter int DEBOUNCE_TICKS = 4,
   parameter int POWERUP_TICKS  = 9
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           clk_en,
   vpg_mode_sel_if.slave  bus
);
   localparam int                PWR_W     = $clog2(POWERUP_TICKS + 1);
   localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
   localparam logic [MODE_W-1:0] DEF_MODE  = MODE_W'(DEFAULT_MODE);

   function automatic logic [MODE_W-1:0] step_up(input logic [MODE_W-1:0] m);
      if (m >= LAST_MODE) step_up = '0;
      else                step_up = m + MODE_W'(1);
   endfunction

   function automatic logic [MODE_W-1:0] step_down(input logic [MODE_W-1:0] m);
      if (m == '0) step_down = LAST_MODE;
      else         step_down = m - MODE_W'(1);
   endfunction

   vpg_state_e        state_r;
   logic [PWR_W-1:0]  pwr_cnt_r;
   logic [MODE_W-1:0] mode_r;
   logic [MODE_W-1:0] queued_r;
   logic              change_r;
   logic              pending_r;

   logic up_rel_s, up_lvl_s, down_rel_s, down_lvl_s;
   logic up_evt_s, down_evt_s, load_ok_s, evt_valid_s;
   logic [MODE_W-1:0] base_s, target_s;

   vpg_key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_up (
      .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
      .key_in(bus.mode_up), .key_level(up_lvl_s), .release_evt(up_rel_s)
   );

   vpg_key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_down (
      .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
      .key_in(bus.mode_down), .key_level(down_lvl_s), .release_evt(down_rel_s)
   );

   assign up_evt_s   = up_rel_s & up_lvl_s;
   assign down_evt_s = down_rel_s & down_lvl_s;
   assign load_ok_s  = (32'(bus.mode_load_value) < 32'(NUM_MODES));

   // Target mode; a load (even an illegal one) masks the keys, and steps
   // start from the queued target so repeated presses accumulate.
   always_comb begin
      base_s      = pending_r ? queued_r : mode_r;
      evt_valid_s = 1'b0;
      target_s    = base_s;
      if (bus.mode_load) begin
         evt_valid_s = load_ok_s;
         target_s    = bus.mode_load_value;
      end else if (up_evt_s && !down_evt_s) begin
         evt_valid_s = 1'b1;
         target_s    = step_up(base_s);
      end else if (down_evt_s && !up_evt_s) begin
         evt_valid_s = 1'b1;
         target_s    = step_down(base_s);
      end else begin
         evt_valid_s = 1'b0;
         target_s    = base_s;
      end
   end

   // Request state machine with registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= S_PWRUP;
         pwr_cnt_r <= '0;
         mode_r    <= DEF_MODE;
         queued_r  <= DEF_MODE;
         change_r  <= 1'b0;
         pending_r <= 1'b0;
      end else if (clk_en) begin
         case (state_r)
            S_PWRUP: begin
               pwr_cnt_r <= pwr_cnt_r + PWR_W'(1);
               if (pwr_cnt_r == PWR_W'(POWERUP_TICKS - 1)) begin
                  state_r  <= S_REQ;
                  mode_r   <= DEF_MODE;
                  change_r <= 1'b1;
               end
            end
            S_IDLE: begin
               if (evt_valid_s) begin
                  state_r  <= S_REQ;
                  mode_r   <= target_s;
                  change_r <= 1'b1;
               end
            end
            S_REQ: begin
               // A same-tick event is queued and immediately consumed by the ack.
               if (bus.mode_ack) begin
                  pending_r <= 1'b0;
                  if (evt_valid_s) begin
                     mode_r <= target_s;
                  end else if (pending_r) begin
                     mode_r <= queued_r;
                  end else begin
                     change_r <= 1'b0;
                     state_r  <= S_IDLE;
                  end
               end else if (evt_valid_s) begin
                  queued_r  <= target_s;
                  pending_r <= 1'b1;
               end
            end
            default: begin
               state_r   <= S_PWRUP;
               pwr_cnt_r <= '0;
               change_r  <= 1'b0;
               pending_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.vpg_mode_change = change_r;
   assign bus.vpg_mode        = mode_r;
   assign bus.pending         = pending_r;

endmodule

// File: tb/tb_vpg_mode_sel.sv
// Bench for vpg_mode_sel: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_vpg_mode_sel;
   localparam int NUM = 10;
   localparam int DB  = 4;
   localparam int PW  = 9;
   localparam int DEF = 0;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clk_en = 1'b1;
   int   checks = 0;
   int   errors = 0;

   vpg_mode_sel_if #(.MODE_W(4)) bus ();

   vpg_mode_sel #(
      .MODE_W(4), .NUM_MODES(NUM), .DEFAULT_MODE(DEF),
      .DEBOUNCE_TICKS(DB), .POWERUP_TICKS(PW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit en, up, down, load;
      int val;
      bit ack;
      int exp_c, exp_m, exp_p;
   } vec_t;
   vec_t vq[$];

   // behavioural reference state
   bit model_on = 1'b0;
   bit m_powered, m_change, m_pending;
   int m_ticks, m_mode, m_queued;
   bit m_lvl[2];
   int m_run[2];
   bit m_evt[2];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outs(input string name, input int c, input int m, input int p);
      chk({name, "_change"}, int'(bus.vpg_mode_change), c);
      chk({name, "_mode"}, int'(bus.vpg_mode), m);
      chk({name, "_pending"}, int'(bus.pending), p);
   endtask

   task automatic model_reset();
      m_powered = 0; m_change = 0; m_pending = 0;
      m_ticks = 0; m_mode = DEF; m_queued = DEF;
      for (int k = 0; k < 2; k++) begin
         m_lvl[k] = 1; m_run[k] = 0; m_evt[k] = 0;
      end
   endtask

   task automatic model_step();
      bit v;
      int t, base;
      bit raw;
      base = m_pending ? m_queued : m_mode;
      v = 0;
      t = base;
      if (bus.mode_load) begin
         v = (int'(bus.mode_load_value) < NUM);
         t = int'(bus.mode_load_value);
      end else if (m_evt[0] != m_evt[1]) begin
         v = 1;
         t = m_evt[0] ? (base + 1) % NUM : (base + NUM - 1) % NUM;
      end
      if (!m_powered) begin
         m_ticks++;
         if (m_ticks == PW) begin
            m_powered = 1; m_mode = DEF; m_change = 1;
         end
      end else if (!m_change) begin
         if (v) begin
            m_mode = t; m_change = 1;
         end
      end else begin
         if (v) begin
            m_queued = t; m_pending = 1;
         end
         if (bus.mode_ack) begin
            if (m_pending) begin
               m_mode = m_queued; m_pending = 0;
            end else begin
               m_change = 0;
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         raw = (k == 0) ? bus.mode_up : bus.mode_down;
         m_evt[k] = 0;
         if (raw != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == DB) begin
               m_lvl[k] = raw; m_run[k] = 0; m_evt[k] = raw;
            end
         end else begin
            m_run[k] = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (model_on && clk_en) model_step();
      #1;
   endtask

   task automatic idle_inputs();
      bus.mode_up = 1'b1; bus.mode_down = 1'b1; bus.mode_load = 1'b0;
      bus.mode_load_value = 4'd0; bus.mode_ack = 1'b0; clk_en = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic keys(input bit u, input bit d, input int n);
      bus.mode_up = u; bus.mode_down = d;
      repeat (n) tick();
   endtask

   task automatic load(input int v);
      bus.mode_load = 1'b1; bus.mode_load_value = 4'(v);
      tick();
      bus.mode_load = 1'b0;
   endtask

   task automatic ack();
      bus.mode_ack = 1'b1;
      tick();
      bus.mode_ack = 1'b0;
   endtask

   task automatic add(input bit en, input bit load_i, input int val, input bit ack_i,
                      input int c, input int m, input int p);
      vec_t r;
      r.en = en; r.up = 1; r.down = 1; r.load = load_i; r.val = val; r.ack = ack_i;
      r.exp_c = c; r.exp_m = m; r.exp_p = p;
      vq.push_back(r);
   endtask

   initial begin
      idle_inputs();

      // power-up, loads, queueing, ack handling, clk_en hold
      for (int i = 0; i < PW - 1; i++) add(1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0);
      add(1, 1, 12, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      add(1, 1, 5, 0, 1, 5, 0);
      add(1, 1, 3, 0, 1, 5, 1);
      add(1, 1, 15, 0, 1, 5, 1);
      add(1, 0, 0, 1, 1, 3, 0);
      add(0, 0, 0, 1, 1, 3, 0);
      add(1, 0, 0, 1, 0, 3, 0);
      add(1, 0, 0, 1, 0, 3, 0);
      add(1, 1, 3, 0, 1, 3, 0);
      add(1, 1, 7, 1, 1, 7, 0);
      add(1, 0, 0, 1, 0, 7, 0);

      do_reset();
      chk_outs("reset", 0, 0, 0);
      foreach (vq[i]) begin
         clk_en = vq[i].en;
         bus.mode_up = vq[i].up; bus.mode_down = vq[i].down;
         bus.mode_load = vq[i].load; bus.mode_load_value = 4'(vq[i].val);
         bus.mode_ack = vq[i].ack;
         tick();
         chk_outs($sformatf("vec%0d", i), vq[i].exp_c, vq[i].exp_m, vq[i].exp_p);
      end
      idle_inputs();

      // key stepping with wrap-around, queued step and ack
      do_reset();
      repeat (PW) tick();
      chk_outs("pwrup", 1, 0, 0);
      ack();
      load(9);
      chk_outs("ld9", 1, 9, 0);
      ack();
      chk_outs("ack9", 0, 9, 0);
      keys(0, 1, DB);
      keys(1, 1, DB);
      chk_outs("up_latency", 0, 9, 0);
      tick();
      chk_outs("up_wrap", 1, 0, 0);
      keys(1, 0, DB);
      keys(1, 1, DB);
      tick();
      chk_outs("down_queue", 1, 0, 1);
      ack();
      chk_outs("ack_queued", 1, 9, 0);
      ack();
      chk_outs("ack_idle", 0, 9, 0);

      // glitch shorter than the debounce window
      keys(0, 1, DB - 2);
      keys(1, 1, 10);
      chk_outs("glitch", 0, 9, 0);

      // simultaneous up and down releases cancel
      keys(0, 0, DB);
      keys(1, 1, DB + 1);
      chk_outs("up_down", 0, 9, 0);

      // load beats a same-tick up event
      keys(0, 1, DB);
      keys(1, 1, DB);
      load(5);
      chk_outs("load_prio", 1, 5, 0);
      ack();
      chk_outs("load_prio_ack", 0, 5, 0);

      // clk_en low freezes everything mid-request
      load(2);
      load(4);
      chk_outs("pre_freeze", 1, 2, 1);
      clk_en = 1'b0;
      for (int i = 0; i < 100; i++) begin
         bus.mode_up = 1'($urandom); bus.mode_down = 1'($urandom);
         bus.mode_ack = 1'($urandom); bus.mode_load = 1'($urandom);
         bus.mode_load_value = 4'($urandom);
         tick();
         chk_outs("freeze", 1, 2, 1);
      end
      idle_inputs();
      ack();
      chk_outs("post_freeze", 1, 4, 0);
      ack();

      // asynchronous reset in the middle of a request
      load(7);
      chk_outs("pre_rst", 1, 7, 0);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk_outs("async_rst", 0, 0, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (PW - 1) tick();
      chk_outs("rerun_early", 0, 0, 0);
      tick();
      chk_outs("rerun_pwrup", 1, 0, 0);

      // randomized run against the reference model
      do_reset();
      model_on = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) bus.mode_up = ~bus.mode_up;
         if ($urandom_range(0, 5) == 0) bus.mode_down = ~bus.mode_down;
         bus.mode_load = ($urandom_range(0, 11) == 0);
         bus.mode_load_value = 4'($urandom_range(0, 15));
         bus.mode_ack = ($urandom_range(0, 3) == 0);
         clk_en = ($urandom_range(0, 7) != 0);
         tick();
         chk_outs("rnd", int'(m_change), m_mode, int'(m_pending));
      end
      model_on = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
